// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Grants, latches operands, registers the ALU result and returns it with done.
module alu_arbiter #(
   parameter int WIDTH     = 4,
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [1:0]       op0,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] res,
   output logic             ovr,
   output logic             cout,
   output logic             owner,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_s0,
   output logic             alu_s1,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_ovr,
   input  logic             alu_cout
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   state_t state, state_n;

   logic             grant;
   logic             win_n;
   logic             win;
   logic             prio;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Contention resolves to prio; a lone request simply wins.
   always_comb begin
      state_n = state;
      grant   = 1'b0;
      win_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req0 | req1) begin
               grant   = 1'b1;
               win_n   = (req0 & req1) ? prio : req1;
               state_n = EXEC;
            end
         end
         EXEC:    state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         win   <= 1'b0;
         prio  <= PRIO_INIT;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         res   <= '0;
         ovr   <= 1'b0;
         cout  <= 1'b0;
         owner <= 1'b0;
      end else begin
         gnt0  <= grant & ~win_n;
         gnt1  <= grant & win_n;
         done0 <= (state == DONE) & ~win;
         done1 <= (state == DONE) & win;
         if (grant) begin
            a_q  <= win_n ? a1 : a0;
            b_q  <= win_n ? b1 : b0;
            op_q <= win_n ? op1 : op0;
            win  <= win_n;
            prio <= ~win_n;
         end
         if (state == EXEC) begin
            res   <= alu_r;
            ovr   <= alu_ovr;
            cout  <= alu_cout;
            owner <= win;
         end
      end
   end

   assign busy   = (state != IDLE);
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign alu_s0 = op_q[0];
   assign alu_s1 = op_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 4-bit ALU.
// Directed requests push expected results; a monitor checks each done.
module tb_alu_arbiter;

   typedef struct packed {
      logic       own;
      logic [3:0] res;
      logic       ovr;
      logic       cout;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1;
   logic [1:0] op0, op1;
   logic [3:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, done0, done1;
   logic [3:0] res;
   logic       ovr, cout, owner, busy;
   logic [3:0] alu_a, alu_b;
   logic       alu_s0, alu_s1;
   logic [3:0] alu_r;
   logic       alu_ovr, alu_cout;
   logic [4:0] sum;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   exp_t sbq[$];

   alu_arbiter #(.WIDTH(4), .PRIO_INIT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .res(res), .ovr(ovr), .cout(cout),
      .owner(owner), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_s0(alu_s0), .alu_s1(alu_s1),
      .alu_r(alu_r), .alu_ovr(alu_ovr), .alu_cout(alu_cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      sum      = 5'd0;
      alu_r    = 4'd0;
      alu_ovr  = 1'b0;
      alu_cout = 1'b0;
      case ({alu_s1, alu_s0})
         2'b00: begin
            sum      = {1'b0, alu_a} + {1'b0, alu_b};
            alu_r    = sum[3:0];
            alu_cout = sum[4];
            alu_ovr  = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
         end
         2'b01: begin
            sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            alu_r    = sum[3:0];
            alu_cout = sum[4];
            alu_ovr  = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
         end
         2'b10:   alu_r = alu_a & alu_b;
         default: alu_r = alu_a ^ alu_b;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
      end
   endtask

   function automatic exp_t mk(input logic o, input logic [3:0] r,
                               input logic v, input logic c);
      exp_t e;
      e.own  = o;
      e.res  = r;
      e.ovr  = v;
      e.cout = c;
      return e;
   endfunction

   // Monitor: every done pops one expected response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt0 || gnt1) chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
         if (done0 || done1) begin
            exp_t e;
            done_cnt++;
            chk("done_excl", {31'd0, done0 & done1}, 32'd0);
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("done_port", {31'd0, done1}, {31'd0, e.own});
               chk("owner", {31'd0, owner}, {31'd0, e.own});
               chk("res", {28'd0, res}, {28'd0, e.res});
               chk("flags", {30'd0, ovr, cout}, {30'd0, e.ovr, e.cout});
            end
         end
      end
   end

   task automatic issue(input bit p, input logic [1:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input exp_t e);
      sbq.push_back(e);
      if (p) begin
         op1 = op; a1 = a; b1 = b; req1 = 1'b1;
      end else begin
         op0 = op; a0 = a; b0 = b; req0 = 1'b1;
      end
   endtask

   task automatic wait_gnt(input bit p, output int gc);
      bit hit = 1'b0;
      gc = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if ((p && gnt1) || (!p && gnt0)) begin
            hit = 1'b1;
            gc  = cyc;
         end
      end
      if (!hit) chk("gnt_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_any_gnt(output bit w, output int gc);
      bit hit = 1'b0;
      w  = 1'b0;
      gc = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            hit = 1'b1;
            w   = gnt1;
            gc  = cyc;
         end
      end
      if (!hit) chk("gnt_any_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_done(output int dc);
      bit hit = 1'b0;
      dc = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (done0 || done1) begin
            hit = 1'b1;
            dc  = cyc;
         end
      end
      if (!hit) chk("done_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle();
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (sbq.size() == 0 && !busy) hit = 1'b1;
      end
      if (!hit) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int  gc, dc, pc, dsave;
      bit  w;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      op0 = 2'd0; op1 = 2'd0;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_res", {28'd0, res}, 32'd0);
      chk("rst_flags", {29'd0, ovr, cout, owner}, 32'd0);
      chk("rst_ctl", {26'd0, busy, gnt0, gnt1, done0, done1, 1'b0}, 32'd0);
      chk("rst_alu", {22'd0, alu_a, alu_b, alu_s1, alu_s0}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Both held: expect 0,1,0,1 with 3-cycle spacing.
      issue(1'b0, 2'b00, 4'd1, 4'd2, mk(1'b0, 4'h3, 1'b0, 1'b0));
      issue(1'b1, 2'b00, 4'd4, 4'd4, mk(1'b1, 4'h8, 1'b1, 1'b0));
      sbq.push_back(mk(1'b0, 4'h3, 1'b0, 1'b0));
      sbq.push_back(mk(1'b1, 4'h8, 1'b1, 1'b0));
      pc = 0;
      for (int k = 0; k < 4; k++) begin
         wait_any_gnt(w, gc);
         chk("rr_order", {31'd0, w}, k % 2);
         if (k > 0) chk("gnt_spacing", gc - pc, 32'd3);
         pc = gc;
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();

      issue(1'b0, 2'b00, 4'd7, 4'd1, mk(1'b0, 4'h8, 1'b1, 1'b0));
      wait_gnt(1'b0, gc);
      req0 = 1'b0;
      wait_done(dc);
      chk("done_latency", dc - gc, 32'd2);
      wait_idle();

      issue(1'b1, 2'b01, 4'd3, 4'd5, mk(1'b1, 4'hE, 1'b0, 1'b0));
      wait_gnt(1'b1, gc);
      req1 = 1'b0;
      wait_idle();
      issue(1'b1, 2'b01, 4'd5, 4'd3, mk(1'b1, 4'h2, 1'b0, 1'b1));
      wait_gnt(1'b1, gc);
      req1 = 1'b0;
      wait_idle();

      issue(1'b0, 2'b10, 4'hC, 4'hA, mk(1'b0, 4'h8, 1'b0, 1'b0));
      wait_gnt(1'b0, gc);
      req0 = 1'b0;
      wait_idle();
      issue(1'b1, 2'b11, 4'hC, 4'hA, mk(1'b1, 4'h6, 1'b0, 1'b0));
      wait_gnt(1'b1, gc);
      req1 = 1'b0;
      wait_idle();

      // Operands changed after the grant must not leak into the op.
      issue(1'b0, 2'b00, 4'd2, 4'd3, mk(1'b0, 4'h5, 1'b0, 1'b0));
      wait_gnt(1'b0, gc);
      req0 = 1'b0;
      a0 = 4'd9; b0 = 4'hF;
      @(negedge clk);
      chk("alu_a_hold", {28'd0, alu_a}, 32'd2);
      chk("alu_b_hold", {28'd0, alu_b}, 32'd3);
      wait_idle();

      // Reset while in EXEC aborts the op.
      op0 = 2'b00; a0 = 4'd1; b0 = 4'd1; req0 = 1'b1;
      wait_gnt(1'b0, gc);
      dsave = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_res", {28'd0, res}, 32'd0);
      chk("abort_busy", {30'd0, busy, done0}, 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_nodone", done_cnt - dsave, 32'd0);
      sbq.push_back(mk(1'b0, 4'h2, 1'b0, 1'b0));
      rst_n = 1'b1;
      wait_gnt(1'b0, gc);
      req0 = 1'b0;
      wait_idle();

      chk("sb_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
